// File: rtl/noc_arb_pkg.sv
// noc_merge_arbiter shared types: flit width, address field, FSM states.
// Imported by the arbiter top and its interface users.
package noc_arb_pkg;
    localparam int FLIT_W  = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_t;

    typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/noc_merge_arbiter_if.sv
// noc_merge_arbiter channel bundle: In0, In1, grant report G, merged Out.
// master = surrounding fabric, slave = the arbiter.
interface noc_merge_arbiter_if #(
    parameter int W = 9
) ();
    logic         in0_valid;
    logic [W-1:0] in0_data;
    logic         in0_ready;
    logic         in1_valid;
    logic [W-1:0] in1_data;
    logic         in1_ready;
    logic         g_valid;
    logic         g_data;
    logic         g_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport master (
        output in0_valid, in0_data,
        input  in0_ready,
        output in1_valid, in1_data,
        input  in1_ready,
        input  g_valid, g_data,
        output g_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  in0_valid, in0_data,
        output in0_ready,
        input  in1_valid, in1_data,
        output in1_ready,
        output g_valid, g_data,
        input  g_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins,
// prio breaks a tie (prio=0 favours req[0]).
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       win_idx
);
    // one-hot (or zero) grant plus its index
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
        win_idx = gnt[1];
    end
endmodule

// File: rtl/noc_merge_arbiter.sv
// 2:1 round-robin merge node: accept one flit, report G, then send Out.
// Optional grant counters when ARB_STATS_EN is defined.
module noc_merge_arbiter
    import noc_arb_pkg::*;
#(
    parameter int W     = FLIT_W,
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              _RESET,
    noc_merge_arbiter_if.slave bus,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);
    arb_state_t   r_state;
    logic         r_prio;
    logic         r_sel_q;
    logic [W-1:0] r_flit_q;

    logic [1:0]   w_req;
    logic [1:0]   w_gnt;
    logic         w_win;
    logic         w_idle;
    logic         w_take;

    assign w_req = {bus.in1_valid, bus.in0_valid};

    rr_pick2 u_pick (
        .req     (w_req),
        .prio    (r_prio),
        .gnt     (w_gnt),
        .win_idx (w_win)
    );

    // handshakes are masked while reset is held so nothing slips through
    assign w_idle        = (r_state == IDLE);
    assign w_take        = w_idle && !_RESET && (w_gnt != 2'b00);
    assign bus.in0_ready = w_take && w_gnt[0];
    assign bus.in1_ready = w_take && w_gnt[1];
    assign bus.g_valid   = (r_state == GRANT) && !_RESET;
    assign bus.g_data    = r_sel_q;
    assign bus.out_valid = (r_state == XFER) && !_RESET;
    assign bus.out_data  = r_flit_q;
    assign busy          = !w_idle;

    // accept -> report grant -> send flit; rotate priority when done
    always_ff @(posedge CLK) begin
        if (_RESET) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_sel_q  <= 1'b0;
            r_flit_q <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_flit_q <= w_win ? bus.in1_data
                                          : bus.in0_data;
                        r_sel_q  <= w_win;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.g_ready) begin
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                        r_prio  <= ~r_sel_q;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // saturating per-input grant counters
    always_ff @(posedge CLK) begin
        if (_RESET) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (bus.in0_ready && r_cnt0 != '1) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (bus.in1_ready && r_cnt1 != '1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif
endmodule

// File: doc/noc_merge_arbiter.md
Name: noc_merge_arbiter

Overview:
- 2:1 round-robin merge arbiter for the NoC tree; the dual of the address-decoding split node.
- Accepts single-flit packets from two upstream channels (child-side In0, sibling/parent-side In1) and serialises them onto one output.
- Reports each grant on a select channel G before the data flit, matching the split node's S-then-Out ordering, so downstream logic can track merge order.
- Sits in the RTL body behind the send/receive channel wrappers; all channels are clocked valid/ready.

Parameters:
- W, 9, flit width (address in bits [8:5], payload below).
- CNT_W, 16, grant-counter width (used only with the optional feature).

Ports:
- CLK  in  1  clock, all state updates on posedge.
- _RESET  in  1  reset, synchronous, active-high (asserted = 1 resets on the next posedge).
- in0_valid  in  1  In0 flit offered.
- in0_data  in  W  In0 flit.
- in0_ready  out  1  In0 flit accepted this cycle.
- in1_valid  in  1  In1 flit offered.
- in1_data  in  W  In1 flit.
- in1_ready  out  1  In1 flit accepted this cycle.
- g_valid  out  1  grant report offered.
- g_data  out  1  winning input index (0 or 1).
- g_ready  in  1  grant report consumed.
- out_valid  out  1  merged flit offered.
- out_data  out  W  merged flit.
- out_ready  in  1  merged flit consumed.
- busy  out  1  high whenever state != IDLE.
- gnt_cnt0  out  CNT_W  In0 grant count (ARB_STATS_EN only).
- gnt_cnt1  out  CNT_W  In1 grant count (ARB_STATS_EN only).

Behaviour:
- A transfer occurs on a channel at a posedge with valid && ready both high.
- State machine, encoding {IDLE, GRANT, XFER}:
  - IDLE → GRANT when either inXvalid is high.
  - GRANT → XFER on g_ready.
  - XFER → IDLE on out_ready.
- IDLE:
  - Winner = the only valid input. If both are valid, winner = prio pointer (prio=0 favours In0).
  - inX_ready is high combinationally for the winner only, and only in IDLE.
  - On acceptance, latch data into flit_q and winner into sel_q.
  - No ready is asserted when neither input is valid.
- GRANT: g_valid=1, g_data=sel_q. Held stable until g_ready. out_valid=0.
- XFER: out_valid=1, out_data=flit_q. Held stable until out_ready.
- On leaving XFER: prio <= ~sel_q (the loser of a contention gets next priority). prio updates after a single-requester grant too.
- Latency: accept at cycle N, g_valid at N+1, out_valid earliest at N+2. Peak throughput is 1 flit per 3 cycles.
- No input is accepted outside IDLE; an input must hold valid and data until accepted.
- A later inX_valid arrival never affects an in-flight flit.
- Reset values: state=IDLE, prio=0, flit_q=0, sel_q=0. All ready/valid outputs 0, g_data=0, out_data=0, busy=0.
- Reset mid-operation drops the latched flit: no G or Out transfer is produced for it.
- g_ready high while g_valid=0 has no effect; the same applies to out_ready.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - gnt_cnt0/gnt_cnt1 increment on each accepted input flit from the respective channel.
  - Counters saturate at 2^CNT_W-1 (no wrap).
  - Reset clears both counters to 0.
- Undefined: counters and their ports are not present; all other behaviour is identical.

Decomposition:
- Package noc_arb_pkg:
  - FLIT_W=9, ADDR_HI=8, ADDR_LO=5.
  - typedef enum logic [1:0] arb_state_t {IDLE, GRANT, XFER}.
  - typedef logic [FLIT_W-1:0] flit_t.
- One sub-module, rr_pick2 (purely combinational):
  - Inputs: req[1:0], prio.
  - Outputs: gnt[1:0] (one-hot or zero), win_idx.

Test Plan:
- Single flit, idle system: in0 offers 9'h1A5, g_ready=out_ready=1.
  - Required: in0_ready at cycle 0; g_valid with g_data=0 at cycle 1; out_valid with out_data=9'h1A5 at cycle 2.
  - After the transfer, prio=1.
- Contention, alternating grants: both inputs valid from reset, in0=9'h011, in1=9'h122.
  - Required grant order 0,1,0,1; out_data sequence 011,122,011,122.
- Back-pressure:
  - g_ready=0 for 4 cycles: g_valid and g_data are held stable, and no inX_ready is asserted.
  - Then out_ready=0 for 3 cycles: out_data is held stable.
- Mid-op reset: _RESET=1 during XFER.
  - Required next cycle: out_valid=0, busy=0, prio=0.
  - Next flit on in1 is granted with g_data=1, and no stale flit appears.
- Stats (ARB_STATS_EN, CNT_W=4): 20 In0 flits.
  - Required: gnt_cnt0 saturates at 15, gnt_cnt1=0.
